// File: rtl/display_pkg.sv
// display_pkg: shared segment codes, digit indices and anode selects for the display driver
package display_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [1:0] D0 = 2'd0;
  localparam logic [1:0] D1 = 2'd1;
  localparam logic [1:0] D2 = 2'd2;
  localparam logic [1:0] D3 = 2'd3;
  localparam logic [3:0] AN_D0 = 4'b0001;
  localparam logic [3:0] AN_D1 = 4'b0010;
  localparam logic [3:0] AN_D2 = 4'b0100;
  localparam logic [3:0] AN_D3 = 4'b1000;
  function automatic logic [3:0] an_onehot(input logic [1:0] d);
    return d == D0 ? AN_D0 : d == D1 ? AN_D1 : d == D2 ? AN_D2 : AN_D3;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit digit to active-high {g..a} segments, codes above 9 go dark
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/counter_display_driver.sv
// counter_display_driver: four-digit multiplexed 7-seg driver for two 4-bit counter values
module counter_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val_a,
  input  logic [3:0] val_b,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [1:0] dig, dig_n;
  logic [3:0] snap_a, snap_b, snap_a_n, snap_b_n, v, digit, an_i;
  logic tick, wrap, tens_sel, act, blank;
  logic [6:0] seg_dec, seg_i;
  seg7_decode u_dec (.digit(digit), .seg(seg_dec));
  // outputs are registered from next-state so seg/dp/an move on the same edge as dig
  always_comb begin
    tick = pcnt == PW'(REFRESH_DIV - 1);
    wrap = tick && dig == D3;
    pcnt_n = tick ? '0 : pcnt + 1'b1;
    dig_n = tick ? dig + 2'd1 : dig;
    snap_a_n = wrap ? val_a : snap_a;
    snap_b_n = wrap ? val_b : snap_b;
    v = dig_n[1] ? snap_b_n : snap_a_n;
    tens_sel = dig_n[0];
    digit = tens_sel ? {3'b000, v >= 4'd10} : (v >= 4'd10 ? v - 4'd10 : v);
    act = pcnt_n >= PW'(GUARD);
    an_i = act ? an_onehot(dig_n) : 4'b0000;
    blank = blank_lz && tens_sel && digit == 4'd0;
    seg_i = blank ? SEG_OFF : seg_dec;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      dig <= D3;
      snap_a <= '0;
      snap_b <= '0;
      an <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp <= ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      pcnt <= pcnt_n;
      dig <= dig_n;
      snap_a <= snap_a_n;
      snap_b <= snap_b_n;
      an <= an_i ^ {4{ACTIVE_LOW}};
      seg <= seg_i ^ {7{ACTIVE_LOW}};
      dp <= (act && dig_n == D2) ^ ACTIVE_LOW;
      frame_start <= wrap;
    end
  end
endmodule

// File: tb/tb_counter_display_driver.sv
// tb_counter_display_driver: directed and random checks against a time-based display model
module tb_counter_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] val_a = '0, val_b = '0;
  logic blank_lz = 1'b0;
  logic [6:0] seg;
  logic dp, frame_start;
  logic [3:0] an;
  int errors = 0, checks = 0, k = 0;
  logic [3:0] sa = '0, sb = '0;
  localparam logic [6:0] TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  always #5 clk = ~clk;
  counter_display_driver #(.REFRESH_DIV(8), .GUARD(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .val_a(val_a), .val_b(val_b), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // k counts rising edges since reset release; digit period index is k/8, frame starts at k%32==8
  task automatic model_check();
    int d, v, dg;
    bit act;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    d = (k / 8 + 3) % 4;
    act = (k % 8) >= 2;
    v = (d < 2) ? int'(sa) : int'(sb);
    dg = (d % 2 == 1) ? v / 10 : v % 10;
    an_e = act ? ~(4'b0001 << d) : 4'hF;
    seg_e = (blank_lz && d % 2 == 1 && dg == 0) ? 7'h7F : ~TBL[dg];
    chk("an", {28'b0, an}, {28'b0, an_e});
    chk("seg", {25'b0, seg}, {25'b0, seg_e});
    chk("dp", {31'b0, dp}, {31'b0, ~(act && d == 2)});
    chk("frame_start", {31'b0, frame_start}, {31'b0, (k >= 8 && k % 32 == 8)});
  endtask
  task automatic cyc(input logic [3:0] a, input logic [3:0] b, input logic bl);
    val_a = a;
    val_b = b;
    blank_lz = bl;
    if ((k + 1) % 32 == 8) begin
      sa = a;
      sb = b;
    end
    @(posedge clk);
    k++;
    #1;
    model_check();
  endtask
  task automatic rcyc();
    cyc(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
  endtask
  initial begin
    int n, fs_cnt, last;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_dp", {31'b0, dp}, 32'h1);
    chk("rst_fs", {31'b0, frame_start}, 32'h0);
    rst = 1'b0;
    repeat (64) cyc(4'd7, 4'd15, 1'b0);
    repeat (40) cyc(4'd3, 4'd15, 1'b1);
    repeat (40) cyc(4'd3, 4'd15, 1'b0);
    n = 0;
    while (k % 32 != 19 && n < 64) begin
      cyc(4'd2, 4'd5, 1'b0);
      n++;
    end
    chk("reach_d1_c3", {31'b0, n < 64}, 32'h1);
    repeat (70) cyc(4'd12, 4'd5, 1'b0);
    repeat (400) rcyc();
    fs_cnt = 0;
    last = -1;
    repeat (320) begin
      rcyc();
      if (frame_start) begin
        if (last >= 0) chk("fs_gap", k - last, 32);
        last = k;
        fs_cnt++;
      end
    end
    chk("fs_count", fs_cnt, 10);
    n = 0;
    while (!((k / 8 + 3) % 4 == 2 && k % 8 >= 2 && k % 8 < 6) && n < 64) begin
      rcyc();
      n++;
    end
    chk("pre_rst_an", {28'b0, an}, 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("async_an", {28'b0, an}, 32'hF);
    chk("async_seg", {25'b0, seg}, 32'h7F);
    chk("async_dp", {31'b0, dp}, 32'h1);
    chk("async_fs", {31'b0, frame_start}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    sa = '0;
    sb = '0;
    n = 0;
    while (an !== 4'b1110 && n < 40) begin
      rcyc();
      n++;
    end
    chk("first_an0_delay", n, 10);
    repeat (100) rcyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
